// File: rtl/piso_serial_tx_if.sv
// Handshake and serial-output bundle for piso_serial_tx.
//   din/load_valid/load_ready : parallel word load handshake (valid/ready)
//   dout/dout_valid/last/busy : serial stream, LSB first, with frame qualifiers
// master modport: the word source / stream consumer; slave modport: the transmitter.
interface piso_serial_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             dout;
  logic             dout_valid;
  logic             last;
  logic             busy;

  modport master (
    output din, load_valid,
    input  load_ready, dout, dout_valid, last, busy
  );

  modport slave (
    input  din, load_valid,
    output load_ready, dout, dout_valid, last, busy
  );
endinterface

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter.
// Accepts a WIDTH-bit word on load_valid && load_ready and shifts it out LSB
// first, one bit per clk, starting the cycle after the accept edge. The final
// bit cycle raises load_ready so a waiting word is taken back-to-back with no
// idle gap.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous reset, active low
//   bus    : piso_serial_tx_if.slave (din, load_valid, load_ready, dout,
//            dout_valid, last, busy)
// Parameters:
//   WIDTH      : word width (>= 2)
//   IDLE_LEVEL : dout level outside a frame
// Build option:
//   PISO_TX_PARITY_EN : when defined, an even-parity bit (^din at accept) is
//   appended after the data bits in state PAR; last/load_ready move to it.
module piso_serial_tx #(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input logic            clk,
  input logic            rst_n,
  piso_serial_tx_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
  logic par;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             msb_bit;
  logic             final_bit;
  logic             ready;
  logic             accept;

  // Data MSB is on dout while cnt sits at WIDTH-1 in SHIFT.
  always_comb begin
    msb_bit = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
`ifdef PISO_TX_PARITY_EN
    final_bit = (state == PAR);
`else
    final_bit = msb_bit;
`endif
    ready  = (state == IDLE) || final_bit;
    accept = bus.load_valid && ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = SHIFT;
      SHIFT: begin
        if (msb_bit) begin
`ifdef PISO_TX_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_TX_PARITY_EN
      PAR:   state_nxt = accept ? SHIFT : IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
`ifdef PISO_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        sreg <= bus.din;
        cnt  <= '0;
`ifdef PISO_TX_PARITY_EN
        par  <= ^bus.din;
`endif
      end else if (state == SHIFT) begin
        sreg <= sreg >> 1;
        cnt  <= cnt + 1'b1;
      end
    end
  end

  // Every output decodes from registered state only; din never reaches dout
  // combinationally.
  always_comb begin
    bus.dout = IDLE_LEVEL;
    if (state == SHIFT) bus.dout = sreg[0];
`ifdef PISO_TX_PARITY_EN
    if (state == PAR) bus.dout = par;
`endif
    bus.dout_valid = (state != IDLE);
    bus.busy       = (state != IDLE);
    bus.last       = final_bit;
    bus.load_ready = ready;
  end
endmodule

// File: tb/tb_piso_serial_tx.sv
// Self-checking bench for piso_serial_tx. Expected outputs come from a
// frame-level model: a frame is the word's bits LSB first (plus ^word when
// PISO_TX_PARITY_EN is defined); outside a frame the line is idle.
module tb_piso_serial_tx;
  localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  piso_serial_tx_if #(.WIDTH(W)) bus ();

  piso_serial_tx #(.WIDTH(W), .IDLE_LEVEL(1'b0)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {dout, dout_valid, last, load_ready, busy}
  logic [4:0] obs;
  assign obs = {bus.dout, bus.dout_valid, bus.last, bus.load_ready, bus.busy};

  // k < 0: idle line; otherwise frame position k of word w.
  function automatic logic [4:0] exp_vec(input logic [W-1:0] w, input int k);
    logic b;
    logic fin;
    if (k < 0) return 5'b00010;
    b   = (k < W) ? w[k] : ^w;
    fin = (k == FL - 1);
    return {b, 1'b1, fin, fin, 1'b1};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.load_valid = 1'b1;
    bus.din = W'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec('0, -1)) begin
        errors++;
        $display("FAIL reset cyc%0d: got %b want %b", i, obs, exp_vec('0, -1));
      end
    end
    bus.load_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== exp_vec('0, -1)) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", obs, exp_vec('0, -1));
    end
  endtask

  task automatic test_single(input logic [W-1:0] w);
    logic [W-1:0] q;
    q = '0;
    bus.din = w;
    bus.load_valid = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.din = W'($urandom);
    for (int k = 0; k < FL; k++) begin
      checks++;
      if (obs !== exp_vec(w, k)) begin
        errors++;
        $display("FAIL single w=%h bit%0d: got %b want %b", w, k, obs, exp_vec(w, k));
      end
      if (k < W) q = {bus.dout, q[W-1:1]};
      @(negedge clk);
    end
    checks++;
    if (obs !== exp_vec('0, -1)) begin
      errors++;
      $display("FAIL single_idle w=%h: got %b want %b", w, obs, exp_vec('0, -1));
    end
    checks++;
    if (q !== w) begin
      errors++;
      $display("FAIL siso_q: got %h want %h", q, w);
    end
  endtask

  task automatic test_back_to_back(input int n);
    logic [W-1:0] ws[$];
    ws.push_back(4'hA);
    ws.push_back(4'h5);
    for (int i = 0; i < n; i++) ws.push_back(W'($urandom));
    bus.din = ws[0];
    bus.load_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < ws.size(); i++) begin
      if (i + 1 < ws.size()) begin
        bus.din = ws[i+1];
        bus.load_valid = 1'b1;
      end else begin
        bus.din = W'($urandom);
        bus.load_valid = 1'b0;
      end
      for (int k = 0; k < FL; k++) begin
        checks++;
        if (obs !== exp_vec(ws[i], k)) begin
          errors++;
          $display("FAIL b2b word%0d=%h bit%0d: got %b want %b", i, ws[i], k, obs, exp_vec(ws[i], k));
        end
        @(negedge clk);
      end
    end
    checks++;
    if (obs !== exp_vec('0, -1)) begin
      errors++;
      $display("FAIL b2b_idle: got %b want %b", obs, exp_vec('0, -1));
    end
  endtask

  // Junk words offered mid-frame must be ignored.
  task automatic test_ignore(input logic [W-1:0] w);
    bus.din = w;
    bus.load_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < FL; k++) begin
      if (k == FL - 1) begin
        bus.load_valid = 1'b0;
      end else begin
        bus.load_valid = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.din = (k == 0) ? 4'hF : W'($urandom);
      end
      checks++;
      if (obs !== exp_vec(w, k)) begin
        errors++;
        $display("FAIL ignore w=%h bit%0d: got %b want %b", w, k, obs, exp_vec(w, k));
      end
      @(negedge clk);
    end
    checks++;
    if (obs !== exp_vec('0, -1)) begin
      errors++;
      $display("FAIL ignore_idle w=%h: got %b want %b", w, obs, exp_vec('0, -1));
    end
  endtask

  task automatic test_reset_mid();
    bus.din = 4'hF;
    bus.load_valid = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs !== exp_vec(4'hF, k)) begin
        errors++;
        $display("FAIL rstmid pre bit%0d: got %b want %b", k, obs, exp_vec(4'hF, k));
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== exp_vec('0, -1)) begin
      errors++;
      $display("FAIL rstmid_async: got %b want %b", obs, exp_vec('0, -1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.din = 4'h9;
    bus.load_valid = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      checks++;
      if (obs !== exp_vec(4'h9, k)) begin
        errors++;
        $display("FAIL rstmid post bit%0d: got %b want %b", k, obs, exp_vec(4'h9, k));
      end
      @(negedge clk);
    end
    checks++;
    if (obs !== exp_vec('0, -1)) begin
      errors++;
      $display("FAIL rstmid_idle: got %b want %b", obs, exp_vec('0, -1));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.din = '0;
    bus.load_valid = 1'b0;
    test_reset();
    test_single(4'hB);
    test_single(4'h7);
    for (int i = 0; i < 6; i++) test_single(W'($urandom));
    test_back_to_back(6);
    test_ignore(4'h3);
    for (int i = 0; i < 3; i++) test_ignore(W'($urandom));
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
